// File: rtl/ir_scan_sched.sv
// ir_scan_sched -- time-multiplexed scheduler for up to eight QTRX reflectance sensors.
//
// The block reads one enabled channel at a time. It charges the sensor pin high, then
// releases it and counts clk cycles until the synchronized pin reads low. Reads are
// round-robin: each search starts at the channel after the one last reported.
//
// Optional feature (compile-time macro IR_SCAN_SETTLE_EN): adds a SETTLE state. In that
// state the parity emitter is switched on for SETTLE_CYCLES before the charge begins.
//
// Parameters
//   CHARGE_CYCLES  clk cycles a sensor pin is driven high (4..255)
//   TIMEOUT        largest decay count before a read is abandoned (1..131071)
//   SETTLE_CYCLES  emitter pre-on cycles (only with IR_SCAN_SETTLE_EN)
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   run                        level: permits new reads to start
//   channel_mask[7:0]          channels enabled for scanning
//   sensor_in[7:0]             raw asynchronous pin levels
//   sensor_drive[7:0]          one-hot; 1 = drive the pin high, 0 = release it
//   emitter_even, emitter_odd  IR LED enables for the even and odd channel banks
//   res_valid / res_ready      result handshake
//   res_chan, res_ttd,         channel, time-to-decay in clk cycles,
//   res_timeout                and the flag set when the read hit TIMEOUT
//   busy                       high in any state other than IDLE
module ir_scan_sched #(
    parameter int unsigned CHARGE_CYCLES = 160,
    parameter logic [16:0] TIMEOUT       = 17'd48000,
    parameter int unsigned SETTLE_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [7:0]  channel_mask,
    input  logic [7:0]  sensor_in,
    output logic [7:0]  sensor_drive,
    output logic        emitter_even,
    output logic        emitter_odd,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  res_chan,
    output logic [16:0] res_ttd,
    output logic        res_timeout,
    output logic        busy
);

    // Elaboration-time range check on the parameters.
    if (CHARGE_CYCLES < 4 || CHARGE_CYCLES > 255 || TIMEOUT == 17'd0 ||
        SETTLE_CYCLES == 0) begin : g_param_err
        $error("ir_scan_sched: parameter out of range");
    end

    localparam logic [16:0] CHARGE_LAST = 17'(CHARGE_CYCLES - 1);
`ifdef IR_SCAN_SETTLE_EN
    localparam logic [16:0] SETTLE_LAST = 17'(SETTLE_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCharge = 3'd1,
        StDecay  = 3'd2,
        StReport = 3'd3
`ifdef IR_SCAN_SETTLE_EN
        , StSettle = 3'd4
`endif
    } state_e;

    state_e      r_state;
    logic [2:0]  r_ptr;
    logic [2:0]  r_cur_ch;
    logic [16:0] r_cnt;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [7:0]  r_drive;
    logic        r_em_even;
    logic        r_em_odd;
    logic        r_valid;
    logic [2:0]  r_chan;
    logic [16:0] r_ttd;
    logic        r_timeout;
    logic        r_busy;

    logic [2:0]  w_next_ch;
    logic [2:0]  w_idx;

    // First enabled channel at or after r_ptr, wrapping 7 -> 0. The loop runs from the
    // farthest offset down, so the nearest enabled channel is the last one written.
    always_comb begin
        w_next_ch = r_ptr;
        w_idx     = '0;
        for (int i = 7; i >= 0; i--) begin
            w_idx = r_ptr + i[2:0];
            if (channel_mask[w_idx]) begin
                w_next_ch = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_cur_ch  <= '0;
            r_cnt     <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_drive   <= '0;
            r_em_even <= 1'b0;
            r_em_odd  <= 1'b0;
            r_valid   <= 1'b0;
            r_chan    <= '0;
            r_ttd     <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sync1 <= sensor_in;
            r_sync2 <= r_sync1;
            unique case (r_state)
                StIdle: begin
                    if (run && (channel_mask != 8'h00)) begin
                        r_cur_ch  <= w_next_ch;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_em_even <= ~w_next_ch[0];
                        r_em_odd  <= w_next_ch[0];
`ifdef IR_SCAN_SETTLE_EN
                        r_state   <= StSettle;
`else
                        r_drive   <= 8'd1 << w_next_ch;
                        r_state   <= StCharge;
`endif
                    end
                end
`ifdef IR_SCAN_SETTLE_EN
                StSettle: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_drive <= 8'd1 << r_cur_ch;
                        r_state <= StCharge;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
`endif
                StCharge: begin
                    if (r_cnt == CHARGE_LAST) begin
                        r_cnt   <= '0;
                        r_drive <= '0;
                        r_state <= StDecay;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                StDecay: begin
                    // Timeout takes priority. The counter stops at TIMEOUT, so it never
                    // wraps, and r_cnt already holds TIMEOUT when the read is abandoned.
                    if ((r_cnt == TIMEOUT) || !r_sync2[r_cur_ch]) begin
                        r_ttd     <= r_cnt;
                        r_timeout <= (r_cnt == TIMEOUT);
                        r_chan    <= r_cur_ch;
                        r_valid   <= 1'b1;
                        r_em_even <= 1'b0;
                        r_em_odd  <= 1'b0;
                        r_state   <= StReport;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                StReport: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_cur_ch + 3'd1;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign sensor_drive = r_drive;
    assign emitter_even = r_em_even;
    assign emitter_odd  = r_em_odd;
    assign res_valid    = r_valid;
    assign res_chan     = r_chan;
    assign res_ttd      = r_ttd;
    assign res_timeout  = r_timeout;
    assign busy         = r_busy;

endmodule

// File: tb/tb_ir_scan_sched.sv
// tb_ir_scan_sched -- directed bench for ir_scan_sched.
//
// A pin model charges each sensor while it is driven. Once released, the pin falls
// after a per-channel number of cycles (-1 means it never falls). A reference model
// predicts the channel order and the result of each read. A compare process checks
// the DUT against the model on every falling edge, and directed steps pin the model
// with hand-computed literals.
module tb_ir_scan_sched;

    localparam int CHARGE = 160;
    localparam int TMO    = 48000;
`ifdef IR_SCAN_SETTLE_EN
    localparam int EXP_SETTLE = 32;
`else
    localparam int EXP_SETTLE = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  channel_mask;
    logic [7:0]  sensor_in;
    logic [7:0]  sensor_drive;
    logic        emitter_even;
    logic        emitter_odd;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_chan;
    logic [16:0] res_ttd;
    logic        res_timeout;
    logic        busy;

    ir_scan_sched #(
        .CHARGE_CYCLES(160),
        .TIMEOUT      (17'd48000),
        .SETTLE_CYCLES(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .channel_mask(channel_mask),
        .sensor_in   (sensor_in),
        .sensor_drive(sensor_drive),
        .emitter_even(emitter_even),
        .emitter_odd (emitter_odd),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_chan    (res_chan),
        .res_ttd     (res_ttd),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pin model
    logic [7:0] pin;
    logic [7:0] rand_in;
    bit         rand_en;
    int         decay [8];
    int         since [8];

    assign sensor_in = rand_en ? rand_in : pin;

    initial begin
        pin = '0;
        for (int c = 0; c < 8; c++) since[c] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 8; c++) begin
                if (sensor_drive[c]) begin
                    pin[c]   = 1'b1;
                    since[c] = 0;
                end else if (pin[c] && decay[c] >= 0) begin
                    if (since[c] >= decay[c]) pin[c] = 1'b0;
                    else since[c]++;
                end
            end
        end
    end

    // Reference model and compare process
    typedef struct {
        int ch;
        int ttd;
        int to;
    } res_t;

    res_t       expq [$];
    int         got [$];
    int         mptr = 0;
    int         n_hs = 0;
    int         drive_len = 0;
    int         pre_emit = 0;
    int         last_charge_len = 0;
    bit         after_charge = 0;
    logic [7:0] prev_drive = '0;
    logic [7:0] exp_drive = '0;
    logic       prev_valid = 1'b0;
    int         last_ch = -1;
    int         last_ttd = -1;
    int         last_to = -1;

    function automatic int sel_ch(input logic [7:0] m, input int p);
        for (int k = 0; k < 8; k++) begin
            if (m[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    initial begin
        res_t r;
        int   dch;
        int   ech;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_drive", sensor_drive, 0);
                check("rst_emit", {emitter_even, emitter_odd}, 0);
                check("rst_valid", res_valid, 0);
                check("rst_result", {res_chan, res_ttd, res_timeout}, 0);
                check("rst_busy", busy, 0);
                mptr = 0;
                expq.delete();
                prev_drive = '0;
                prev_valid = 1'b0;
                drive_len = 0;
                pre_emit = 0;
                after_charge = 0;
            end else begin
                check("drive_onehot0", $onehot0(sensor_drive), 1);
                check("emit_exclusive", emitter_even & emitter_odd, 0);
                if (!busy) begin
                    check("idle_quiet", {sensor_drive, emitter_even, emitter_odd, res_valid}, 0);
                end
                if (sensor_drive != 0 && prev_drive == 0) begin
                    dch = 0;
                    for (int c = 0; c < 8; c++) if (sensor_drive[c]) dch = c;
                    ech = sel_ch(channel_mask, mptr);
                    check("chan_select", dch, ech);
                    check("settle_len", pre_emit, EXP_SETTLE);
                    check("emit_parity", {emitter_even, emitter_odd},
                          (dch % 2 == 0) ? 2 : 1);
                    if (ech < 0) ech = dch;
                    exp_drive = 8'd1 << ech;
                    r.ch = ech;
                    if (decay[ech] >= 0 && decay[ech] + 2 < TMO) begin
                        r.ttd = decay[ech] + 2;
                        r.to  = 0;
                    end else begin
                        r.ttd = TMO;
                        r.to  = 1;
                    end
                    expq.push_back(r);
                    drive_len = 1;
                    pre_emit = 0;
                end else if (sensor_drive != 0) begin
                    check("drive_chan", sensor_drive, exp_drive);
                    drive_len++;
                end else if (prev_drive != 0) begin
                    check("charge_len", drive_len, CHARGE);
                    last_charge_len = drive_len;
                    after_charge = 1;
                end
                if (sensor_drive == 0 && (emitter_even || emitter_odd) && !after_charge) begin
                    pre_emit++;
                end
                if (res_valid) begin
                    check("report_quiet", {sensor_drive, emitter_even, emitter_odd}, 0);
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL result_unexpected: got chan %0d expected no result", res_chan);
                    end else begin
                        check("result_chan", res_chan, expq[0].ch);
                        check("result_ttd", res_ttd, expq[0].ttd);
                        check("result_timeout", res_timeout, expq[0].to);
                    end
                    if (!prev_valid) begin
                        last_ch  = int'(res_chan);
                        last_ttd = int'(res_ttd);
                        last_to  = int'(res_timeout);
                    end
                end
                if (res_valid && res_ready) begin
                    if (expq.size() > 0) begin
                        mptr = (expq[0].ch + 1) % 8;
                        void'(expq.pop_front());
                    end
                    got.push_back(int'(res_chan));
                    n_hs++;
                    after_charge = 0;
                end
                prev_valid = res_valid;
                prev_drive = sensor_drive;
            end
        end
    end

    // Stimulus helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: any drive, 1: drive[5], 2: drive released, 3: res_valid
    task automatic wait_for(input int mode, input int budget, input string name);
        int n = 0;
        bit ok = 0;
        while (n < budget) begin
            case (mode)
                0: ok = (sensor_drive != 0);
                1: ok = sensor_drive[5];
                2: ok = (sensor_drive == 0);
                default: ok = res_valid;
            endcase
            if (ok) break;
            tick(1);
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: got no event expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_hs(input int budget, input string name);
        int start = n_hs;
        int n = 0;
        while (n_hs == start && n < budget) begin
            tick(1);
            n++;
        end
        if (n_hs == start) begin
            checks++;
            failures++;
            $display("FAIL %s: got no handshake expected one within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_order [7];
        for (int c = 0; c < 8; c++) decay[c] = 50;
        rst_n = 1'b0;
        run = 1'b0;
        channel_mask = '0;
        res_ready = 1'b1;
        rand_en = 1'b1;
        rand_in = '0;

        // Reset held with random inputs; outputs are checked every cycle.
        repeat (12) begin
            @(posedge clk);
            #1;
            run = 1'($urandom);
            channel_mask = 8'($urandom);
            res_ready = 1'($urandom);
            rand_in = 8'($urandom);
        end
        run = 1'b0;
        channel_mask = '0;
        res_ready = 1'b1;
        rand_en = 1'b0;
        tick(1);
        rst_n = 1'b1;

        // No read starts without run, or with an empty mask.
        channel_mask = 8'hFF;
        tick(5);
        check("idle_no_run", busy, 0);
        channel_mask = 8'h00;
        run = 1'b1;
        tick(5);
        check("idle_empty_mask", busy, 0);

        // Channel 0; the pin falls 100 cycles after release.
        decay[0] = 100;
        channel_mask = 8'h01;
        wait_for(0, 10, "t34_start");
        check("t34_emit_even", {emitter_even, emitter_odd}, 2);
        run = 1'b0;
        wait_hs(1000, "t34_hs");
        check("t34_chan", last_ch, 0);
        check("t34_ttd", last_ttd, 102);
        check("t34_timeout", last_to, 0);
        check("t34_charge_len", last_charge_len, 160);

        // A pin that falls exactly at release reads as 2.
        decay[1] = 0;
        channel_mask = 8'h02;
        run = 1'b1;
        wait_for(0, 100, "t22_start");
        run = 1'b0;
        wait_hs(1000, "t22_hs");
        check("t22_chan", last_ch, 1);
        check("t22_ttd", last_ttd, 2);

        // Channel 3 never decays, so the read times out.
        decay[3] = -1;
        channel_mask = 8'h08;
        run = 1'b1;
        wait_for(0, 100, "t35_start");
        check("t35_emit_odd", {emitter_even, emitter_odd}, 1);
        run = 1'b0;
        wait_hs(50000, "t35_hs");
        check("t35_chan", last_ch, 3);
        check("t35_ttd", last_ttd, 48000);
        check("t35_timeout", last_to, 1);

        // Round-robin order over 8'hA5 from a fresh reset.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        decay[0] = 10;
        decay[2] = 20;
        decay[5] = 30;
        decay[7] = 40;
        channel_mask = 8'hA5;
        base = got.size();
        run = 1'b1;
        repeat (6) wait_hs(1000, "t36_hs");
        wait_for(1, 1000, "t36_ch5");
        run = 1'b0;
        wait_hs(1000, "t36_last_hs");
        tick(20);
        check("t36_busy_after", busy, 0);
        check("t36_count", got.size() - base, 7);
        exp_order = '{0, 2, 5, 7, 0, 2, 5};
        for (int k = 0; k < 7; k++) begin
            if (base + k < got.size()) check("t36_order", got[base + k], exp_order[k]);
        end

        // A mask change mid-read applies only at the next decision.
        decay[4] = 15;
        channel_mask = 8'h30;
        run = 1'b1;
        wait_for(0, 100, "t27_start");
        tick(10);
        channel_mask = 8'h81;
        wait_hs(1000, "t27_hs1");
        check("t27_first", last_ch, 4);
        wait_for(0, 100, "t27_next");
        run = 1'b0;
        wait_hs(1000, "t27_hs2");
        check("t27_second", last_ch, 7);

        // Backpressure: the result is held while res_ready stays low.
        res_ready = 1'b0;
        channel_mask = 8'h01;
        decay[0] = 100;
        run = 1'b1;
        wait_for(0, 100, "t37_start");
        run = 1'b0;
        wait_for(3, 1000, "t37_valid");
        run = 1'b1;
        tick(50);
        check("t37_valid_held", res_valid, 1);
        check("t37_no_charge", sensor_drive, 0);
        check("t37_busy", busy, 1);
        check("t37_ttd", res_ttd, 102);
        run = 1'b0;
        res_ready = 1'b1;
        wait_hs(10, "t37_hs");

        // Asynchronous reset in the middle of CHARGE.
        decay[1] = 5;
        channel_mask = 8'h02;
        run = 1'b1;
        wait_for(0, 100, "t33a_start");
        run = 1'b0;
        tick(5);
        check("t33a_pre_drive", sensor_drive, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t33a_drive", sensor_drive, 0);
        check("t33a_emit", {emitter_even, emitter_odd}, 0);
        tick(2);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of DECAY.
        decay[1] = -1;
        run = 1'b1;
        wait_for(0, 100, "t33b_start");
        run = 1'b0;
        tick(1);
        wait_for(2, 400, "t33b_release");
        tick(10);
        check("t33b_pre_emit", emitter_odd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t33b_emit", {emitter_even, emitter_odd}, 0);
        check("t33b_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
